// File: rtl/rstmgr_pkg.sv
// Shared types and constants for the sequenced SoC reset manager.
package rstmgr_pkg;

  typedef enum logic [1:0] {
    STRETCH = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_state_e;

  localparam int CausePor  = 0;
  localparam int CauseNdm  = 1;
  localparam int CauseSw   = 2;
  localparam int CauseWdog = 3;
  localparam int NumCauses = 4;

  localparam logic [NumCauses-1:0] CauseResetVal = 4'b0001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Multi-flop level synchroniser; clears to 0 while the pad reset is asserted.
module rst_sync #(
  parameter int Stages = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [Stages-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[Stages-2:0], i_d};
    end
  end

  assign o_q = r_sync[Stages-1];

endmodule

// File: rtl/rstmgr_seq.sv
// Reset manager: merges POR with synchronised reset requests, stretches the
// merged reset and releases NumDomains active-low resets in ascending order.
module rstmgr_seq
  import rstmgr_pkg::*;
#(
  parameter int NumDomains    = 3,
  parameter int SyncStages    = 2,
  parameter int StretchCycles = 16,
  parameter int SeqGap        = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ndmreset_i,
  input  logic                  sw_rst_req_i,
  input  logic                  wdog_rst_i,
  input  logic                  prog_hold_i,
  input  logic                  cause_clr_i,
  output logic [NumDomains-1:0] rst_no,
  output logic                  rst_busy_o,
  output logic [NumCauses-1:0]  rst_cause_o
);

  localparam int CntW = $clog2(max_int(StretchCycles, SeqGap) + 1);
  localparam int IdxW = $clog2(NumDomains + 1);

  localparam logic [CntW-1:0] StretchLast = CntW'(StretchCycles - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(SeqGap - 1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(NumDomains - 1);

  // Synchroniser lanes: 0 ndm, 1 sw, 2 wdog, 3 programming hold.
  logic [3:0] w_async;
  logic [3:0] w_sync;

  assign w_async = {prog_hold_i, wdog_rst_i, sw_rst_req_i, ndmreset_i};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    rst_sync #(
      .Stages (SyncStages)
    ) u_rst_sync (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_d     (w_async[gi]),
      .o_q     (w_sync[gi])
    );
  end

  logic w_req_any;
  logic w_restart;
  assign w_req_any = |w_sync[2:0];
  assign w_restart = w_req_any | w_sync[3];

  rst_state_e            r_state;
  logic [CntW-1:0]       r_cnt;
  logic [IdxW-1:0]       r_idx;
  logic [NumDomains-1:0] r_rst_n;
  logic                  r_busy;
  logic [NumCauses-1:0]  r_cause;

  // One-hot select of the domain that the current gap expiry releases.
  logic [NumDomains-1:0] w_rel_mask;
  for (genvar gi = 0; gi < NumDomains; gi++) begin : g_rel_mask
    assign w_rel_mask[gi] = (r_idx == IdxW'(gi));
  end

  logic [NumCauses-1:0] w_cause_set;
  logic [NumCauses-1:0] w_cause_next;

  always_comb begin
    w_cause_set            = '0;
    w_cause_set[CauseNdm]  = w_sync[0];
    w_cause_set[CauseSw]   = w_sync[1];
    w_cause_set[CauseWdog] = w_sync[2];
    // A set on the same edge as a clear must survive.
    w_cause_next = (cause_clr_i ? '0 : r_cause) | w_cause_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= STRETCH;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
      r_cause <= CauseResetVal;
    end else begin
      r_cause <= w_cause_next;
      unique case (r_state)
        STRETCH: begin
          if (w_restart) begin
            r_cnt <= '0;
          end else if (r_cnt == StretchLast) begin
            r_cnt      <= '0;
            r_rst_n[0] <= 1'b1;
            if (NumDomains == 1) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
            end else begin
              r_state <= RELEASE;
              r_idx   <= IdxW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        RELEASE: begin
          if (w_restart) begin
            r_state <= STRETCH;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
          end else if (r_cnt == GapLast) begin
            r_cnt   <= '0;
            r_rst_n <= r_rst_n | w_rel_mask;
            r_idx   <= r_idx + IdxW'(1);
            if (r_idx == IdxLast) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        RUN: begin
          if (w_restart) begin
            r_state <= STRETCH;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= STRETCH;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_rst_n <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign rst_no      = r_rst_n;
  assign rst_busy_o  = r_busy;
  assign rst_cause_o = r_cause;

endmodule
